// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin tree arbiter: FSM encoding and a width helper.
package arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // Index width for n requesters, never less than one bit.
   function automatic int unsigned arb_clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 31; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first eligible request at or above ptr, else
// first eligible request from index 0. Each search is a binary tree of 2-input
// priority nodes, the lower index winning at every node.
module rr_pick
   import arb_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = arb_clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   input  logic [N-1:0]   excl,
   output logic [N-1:0]   win_oh_c,
   output logic [IDW-1:0] win_id_c,
   output logic           any_c
);

   localparam int unsigned P = 1 << IDW;

   typedef struct packed {
      logic           any;
      logic [IDW-1:0] idx;
   } node_t;

   // Reduce a padded request vector level by level, in place, down to node 0.
   function automatic node_t first_set(input logic [P-1:0] v);
      logic [P-1:0]   any_n;
      logic [IDW-1:0] idx_n [P];
      node_t          r;
      any_n = v;
      for (int j = 0; j < int'(P); j++) idx_n[j] = IDW'(j);
      for (int lvl = 0; lvl < int'(IDW); lvl++) begin
         for (int j = 0; j < int'(P >> (lvl + 1)); j++) begin
            idx_n[j] = any_n[2*j] ? idx_n[2*j] : idx_n[2*j+1];
            any_n[j] = any_n[2*j] | any_n[2*j+1];
         end
      end
      r.any = any_n[0];
      r.idx = idx_n[0];
      return r;
   endfunction

   logic [P-1:0] cand;
   logic [P-1:0] above;
   node_t        hi;
   node_t        all;
   node_t        sel;

   // Upper (>= ptr) search takes precedence; the full search supplies the wrap.
   always_comb begin
      cand  = '0;
      above = '0;
      for (int i = 0; i < int'(N); i++) begin
         cand[i]  = req[i] & ~excl[i];
         above[i] = req[i] & ~excl[i] & (IDW'(i) >= ptr);
      end
      hi       = first_set(above);
      all      = first_set(cand);
      sel      = hi.any ? hi : all;
      any_c    = all.any;
      win_id_c = sel.idx;
      win_oh_c = '0;
      for (int i = 0; i < int'(N); i++) begin
         win_oh_c[i] = sel.any & (sel.idx == IDW'(i));
      end
   end

endmodule

// File: rtl/rr_tree_arbiter.sv
// N-requester round-robin arbiter with grant hold and zero-bubble handover.
// Optional forced rotation after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_tree_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = arb_clog2(N)
`ifdef ARB_TIMEOUT_EN
   ,
   parameter int unsigned MAX_HOLD = 8
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   grant,
   output logic           grant_valid,
   output logic [IDW-1:0] grant_id
);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [N-1:0]   grant_q, grant_d;
   logic           grant_valid_q, grant_valid_d;
   logic [IDW-1:0] grant_id_q, grant_id_d;

   logic [N-1:0]   win_oh;
   logic [IDW-1:0] win_id;
   logic           win_any;
   logic           owner_req;
   logic           expired;
   logic           take;

   // The current owner is excluded so a handover always goes to someone else.
   rr_pick #(.N(N), .IDW(IDW)) u_pick (
      .req      (req),
      .ptr      (ptr_q),
      .excl     (grant_q),
      .win_oh_c (win_oh),
      .win_id_c (win_id),
      .any_c    (win_any)
   );

   assign owner_req = |(req & grant_q);

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] hold_q, hold_d;

   // Forced rotation only when someone else is actually waiting.
   assign expired = (hold_q == HOLD_LAST) && win_any;

   // Hold counter: clears on every new grant, saturates at the rotation point.
   always_comb begin
      hold_d = hold_q;
      if (take) begin
         hold_d = '0;
      end else if ((state_q == ST_GRANT) && (hold_q != HOLD_LAST)) begin
         hold_d = hold_q + 8'd1;
      end
   end

   // Hold counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) hold_q <= '0;
      else        hold_q <= hold_d;
   end
`else
   assign expired = 1'b0;
`endif

   // Next-state, pointer and grant selection.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      take       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_any) take = 1'b1;
         end
         ST_GRANT: begin
            if (!owner_req || expired) begin
               if (win_any) begin
                  take = 1'b1;
               end else begin
                  state_d    = ST_IDLE;
                  grant_d    = '0;
                  grant_id_d = '0;
               end
            end
         end
      endcase
      if (take) begin
         state_d    = ST_GRANT;
         grant_d    = win_oh;
         grant_id_d = win_id;
         ptr_d      = (win_id == IDW'(N - 1)) ? '0 : IDW'(win_id + 1'b1);
      end
      grant_valid_d = |grant_d;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         ptr_q         <= '0;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_rr_tree_arbiter.sv
// Self-checking bench for rr_tree_arbiter (N=4): directed vector table, reset and
// rotation sequences, then a random soak against a behavioural reference model.
module tb_rr_tree_arbiter;

   localparam int unsigned N        = 4;
   localparam int unsigned IDW      = 2;
   localparam int unsigned MAX_HOLD = 8;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req   = '0;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [IDW-1:0] grant_id;

   always #5 clk = ~clk;

   rr_tree_arbiter #(.N(N)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] g;
      logic [1:0] id;
   } vec_t;

   vec_t       tbl[$];
   int         checks   = 0;
   int         failures = 0;

   logic [3:0] sr;
   logic [3:0] hreq;
   logic [3:0] prev_g;
   int         m_owner;
   int         m_ptr;
   int         m_hold;
   int         w;
   int         cnt;
   int         newj;
   int         waitc[N];
   logic       keep;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] eid);
      chk({tag, ".grant"}, 32'(grant), 32'(eg));
      chk({tag, ".valid"}, 32'(grant_valid), 32'(|eg));
      chk({tag, ".id"}, 32'(grant_id), 32'(eid));
   endtask

   // Drive req right after an edge, then sample 1 time unit after the next edge.
   task automatic step(input string tag, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eid);
      req = r;
      @(posedge clk);
      #1;
      chk_out(tag, eg, eid);
   endtask

   function automatic int pick(input logic [3:0] r, input int p, input int ex);
      int idx;
      for (int k = 0; k < int'(N); k++) begin
         idx = (p + k) % int'(N);
         if (idx != ex && r[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] id);
      vec_t v;
      v.req = r;
      v.g   = g;
      v.id  = id;
      tbl.push_back(v);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef ARB_TIMEOUT_EN
      hreq = 4'b0001;
`else
      hreq = 4'b0011;
`endif
      for (int i = 0; i < 5; i++) add(4'b0000, 4'b0000, 2'd0);
      add(4'b1111, 4'b0001, 2'd0);
      add(4'b1110, 4'b0010, 2'd1);
      add(4'b1101, 4'b0100, 2'd2);
      add(4'b1011, 4'b1000, 2'd3);
      add(4'b0111, 4'b0001, 2'd0);
      for (int i = 0; i < 10; i++) add(hreq, 4'b0001, 2'd0);
      add(4'b0010, 4'b0010, 2'd1);
      add(4'b0000, 4'b0000, 2'd0);
      add(4'b0100, 4'b0100, 2'd2);
      add(4'b1001, 4'b1000, 2'd3);
      add(4'b0001, 4'b0001, 2'd0);
      add(4'b0011, 4'b0001, 2'd0);
      add(4'b0000, 4'b0000, 2'd0);

      // Reset state.
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_out("reset", 4'b0000, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vector table.
      foreach (tbl[i]) begin
         step($sformatf("vec%0d", i), tbl[i].req, tbl[i].g, tbl[i].id);
      end

      // Async reset in the middle of a grant, then recovery with ptr back at 0.
      step("pre_rst", 4'b0100, 4'b0100, 2'd2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", 4'b0000, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0100;
      @(posedge clk);
      #1;
      chk_out("post_rst", 4'b0100, 2'd2);
      step("ptr3_wrap", 4'b1011, 4'b1000, 2'd3);
      step("to_ptr2", 4'b0010, 4'b0010, 2'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_out("async_rst2", 4'b0000, 2'd0);
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b1001;
      @(posedge clk);
      #1;
      chk_out("ptr_cleared", 4'b0001, 2'd0);

`ifdef ARB_TIMEOUT_EN
      // Forced rotation after MAX_HOLD cycles; lone owner keeps its grant.
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      req   = 4'b0011;
      cnt   = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (grant == 4'b0001) cnt++;
         else break;
      end
      chk("timeout_len", 32'(cnt), 32'(MAX_HOLD));
      chk("timeout_next", 32'(grant), 32'(4'b0010));
      step("lone_take", 4'b0001, 4'b0001, 2'd0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
      end
      #1;
      chk_out("lone_hold", 4'b0001, 2'd0);
`endif

      // Random soak against the reference model.
      @(negedge clk);
      rst_n   = 1'b0;
      req     = '0;
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
      prev_g  = '0;
      for (int i = 0; i < int'(N); i++) waitc[i] = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         sr = 4'($urandom);
         if (m_owner >= 0 && $urandom_range(3) != 0) sr[m_owner] = 1'b1;
         req = sr;
         @(posedge clk);
         keep = (m_owner >= 0) && sr[m_owner];
`ifdef ARB_TIMEOUT_EN
         if (keep && m_hold == int'(MAX_HOLD) - 1 && pick(sr, m_ptr, m_owner) >= 0) keep = 1'b0;
`endif
         if (keep) begin
            if (m_hold != int'(MAX_HOLD) - 1) m_hold++;
         end else begin
            w = pick(sr, m_ptr, m_owner);
            if (w >= 0) begin
               m_owner = w;
               m_ptr   = (w + 1) % int'(N);
               m_hold  = 0;
            end else begin
               m_owner = -1;
            end
         end
         #1;
         if (m_owner >= 0) chk_out("soak", 4'(4'b0001 << m_owner), 2'(m_owner));
         else              chk_out("soak", 4'b0000, 2'd0);
         chk("soak.onehot", 32'($onehot0(grant)), 32'd1);
         // Fairness: a continuously requesting client sees at most N-1 other grants.
         newj = -1;
         if (grant != 4'b0000 && grant != prev_g) begin
            for (int i = 0; i < int'(N); i++) if (grant[i]) newj = i;
         end
         for (int i = 0; i < int'(N); i++) begin
            if (!sr[i] || i == newj) begin
               waitc[i] = 0;
            end else if (newj >= 0) begin
               waitc[i]++;
               chk($sformatf("fair%0d", i), 32'(waitc[i] > int'(N) - 1), 32'd0);
            end
         end
         prev_g = grant;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_tree_arbiter.md
Name: rr_tree_arbiter

Overview:
- Clocked N-requester round-robin arbiter; parametrised successor to the two-input cascaded tree arbiter.
- Grants exactly one requester and holds the grant until that requester drops its request.
- Fair rotation among simultaneous requesters, zero-bubble handover, one-hot plus encoded grant outputs.
- Sits between shared-resource clients (bus, memory port) and the resource mux select.

Parameters:
- N, 4, number of requesters (2..32).
- IDW, $clog2(N) (min 1), width of grant_id.
- MAX_HOLD, 8, cycles before forced rotation; only used when ARB_TIMEOUT_EN is defined (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request, level; bit i = requester i.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- grant_valid  output  1  OR of grant, registered.
- grant_id  output  IDW  index of granted requester; 0 when idle.

Behaviour:
- Reset (async assert, sync release): grant=0, grant_valid=0, grant_id=0, state=IDLE, priority pointer ptr=0, hold counter=0.
- States: IDLE (no owner), GRANT (owner = grant_id).
- Winner selection: first set bit of req scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (wrap at N).
- IDLE: at an edge where req!=0, register the winner; grant visible the following cycle (1-cycle latency), state goes to GRANT. Stays IDLE while req==0.
- GRANT: owner keeps its grant while req[owner]=1, regardless of other requests.
- Release: at an edge where req[owner]=0:
  - other requests present -> grant the next winner directly, same edge, no idle cycle, state stays GRANT;
  - none -> grant=0, state goes to IDLE.
- Pointer: whenever a new grant is registered to index i, ptr becomes (i+1) mod N; ptr is unchanged while holding or idle.
- Simultaneous events: the owner's own drop and others' raises at the same edge are handled by the release rule; the owner is excluded from that selection.
- Invariants:
  - grant is always one-hot or zero; no cycle ever has two bits set.
  - grant_id is consistent with grant every cycle.
- A requester granted in the same cycle it drops req (registered latency) holds for at least one cycle; clients must tolerate this.
- Reset mid-grant: outputs clear immediately, asynchronously; ptr returns to 0.
- N=2 degenerates to alternating priority between two requesters.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - 8-bit hold counter clears on each new grant and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 and any other req bit is set, the grant is forcibly passed to the next winner at that edge, as in release; the owner is excluded.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates.
- Not defined: no counter; grant is held indefinitely while req[owner]=1.

Decomposition:
- Shared package/header arb_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1;
  - clog2 helper for IDW.
- Sub-module rr_pick:
  - combinational masked round-robin picker built as a binary tree of 2-input priority nodes (log2 N levels).
  - Inputs: req vector, ptr, exclude mask.
  - Outputs: one-hot winner, winner index, any.
- The top level holds the FSM, ptr, counter and output registers.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=0 for 5 cycles -> grant=0, grant_valid=0, grant_id=0 throughout.
- Simultaneous start: req=4'b1111 from reset -> next cycle grant=0001; drop req0 -> grant=0010 with no idle gap; then 0100, 1000, then back to 0001.
- Hold and drop: req=4'b0011, owner 0 held 10 cycles -> grant stays 0001; drop req0 -> next cycle grant=0010, ptr=2; drop all -> grant=0 and state IDLE next cycle.
- Wrap-around: ptr=3, req=4'b1001 -> grant=1000; release -> grant=0001.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=8): req=4'b0011 held -> grant 0001 for exactly 8 cycles, then 0010; with req=4'b0001 only -> 0001 held indefinitely.
- Async reset mid-grant: assert rst_n=0 while grant=0100 -> grant=0 before the next clk edge; after release with req=4'b0100 -> grant=0100 one cycle later, ptr=3. Random-req soak checks one-hot and the fairness bound (wait ≤ N-1 grants).
